sc_core_oz_alu_arb: RTL and testbench

Round-robin arbiter that shares the core's single combinational ALU between `NUM_REQ` requesters (e.g. execute stage and a debug/CSR engine). It accepts one operation per cycle via a valid/ready handshake, drives the ALU, and registers the result into a one-entry response slot tagged with the winning requester ID. It sits beside the execute stage and owns the only ALU instance those requesters use.

---
 rtl/sc_core_oz_alu_arb.sv | 216 +++++++++++++++++++++
 tb/tb_sc_core_oz_alu_arb.sv | 340 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sc_core_oz_alu_arb.sv
// ---------------------------------------------------------------------------
// sc_core_oz_alu_arb
//
// Shares one combinational ALU between NUM_REQ requesters. Each cycle a
// round-robin arbiter picks one pending request. The request is accepted when
// the single-entry response slot is empty or is being drained in the same
// cycle. The ALU result is registered into the slot and tagged with the
// winning requester ID.
//
// Optional feature macro: SC_CORE_OZ_ALU_ARB_PERF_EN
//   When defined, the perf_grant_cnt port and its per-requester saturating
//   grant counters are present.
//
// Ports
//   clk            in   core clock, all state updates on the rising edge
//   rst            in   synchronous active-high reset
//   req_valid      in   [NUM_REQ]        requester i has an operation pending
//   req_op         in   [NUM_REQ] alu_op_e  operation per requester
//   req_src1       in   [NUM_REQ][31:0]  operand 1 per requester
//   req_src2       in   [NUM_REQ][31:0]  operand 2 per requester
//   req_ready      out  [NUM_REQ]        one-hot accept for the winner
//   rsp_valid      out  response slot holds a result
//   rsp_id         out  [ID_W]           requester that owns the result
//   rsp_data       out  [31:0]           registered ALU result
//   rsp_ready      in   consumer takes the response this cycle
//   perf_grant_cnt out  [NUM_REQ][15:0]  grant counters (perf build only)
// ---------------------------------------------------------------------------
package sc_core_oz_alu_arb_pkg;
  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_SLL  = 4'd2,
    ALU_SLT  = 4'd3,
    ALU_SLTU = 4'd4,
    ALU_XOR  = 4'd5,
    ALU_SRL  = 4'd6,
    ALU_SRA  = 4'd7,
    ALU_OR   = 4'd8,
    ALU_AND  = 4'd9
  } alu_op_e;
endpackage

module sc_core_oz_alu_arb
  import sc_core_oz_alu_arb_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int ID_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NUM_REQ-1:0]           req_valid,
  input  alu_op_e [NUM_REQ-1:0]        req_op,
  input  logic [NUM_REQ-1:0][31:0]     req_src1,
  input  logic [NUM_REQ-1:0][31:0]     req_src2,
  output logic [NUM_REQ-1:0]           req_ready,
  output logic                         rsp_valid,
  output logic [ID_W-1:0]              rsp_id,
  output logic [31:0]                  rsp_data,
  input  logic                         rsp_ready
`ifdef SC_CORE_OZ_ALU_ARB_PERF_EN
  ,
  output logic [NUM_REQ-1:0][15:0]     perf_grant_cnt
`endif
);

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } state_e;

  state_e            state_reg, state_next;
  logic [ID_W-1:0]   rsp_id_reg, rsp_id_next;
  logic [31:0]       rsp_data_reg, rsp_data_next;
  logic [ID_W-1:0]   rr_ptr_reg, rr_ptr_next;

  logic              can_accept;
  logic              accept;
  logic [NUM_REQ-1:0] at_or_after_ptr;
  logic              hi_found, any_valid;
  logic [ID_W-1:0]   hi_idx, lo_idx, grant_idx;

  alu_op_e           alu_op;
  logic [31:0]       alu_src1, alu_src2, alu_result;
  logic [4:0]        shamt;

  // ---------------------------------------------------------------------
  // Round-robin pick: the lowest valid index at or after rr_ptr wins; if
  // there is none, wrap around and take the lowest valid index overall.
  // ---------------------------------------------------------------------
  generate
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_elig
      assign at_or_after_ptr[gi] = (ID_W'(gi) >= rr_ptr_reg);
    end
  endgenerate

  always_comb begin
    hi_found  = 1'b0;
    any_valid = 1'b0;
    hi_idx    = '0;
    lo_idx    = '0;
    // Walk downwards so the last hit is the lowest index.
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (req_valid[k] && at_or_after_ptr[k]) begin
        hi_found = 1'b1;
        hi_idx   = ID_W'(k);
      end
      if (req_valid[k]) begin
        any_valid = 1'b1;
        lo_idx    = ID_W'(k);
      end
    end
  end

  assign grant_idx  = hi_found ? hi_idx : lo_idx;
  assign can_accept = (state_reg == ST_EMPTY) || rsp_ready;
  // Nothing is accepted while reset is held, so no requester sees a
  // handshake that the reset would then throw away.
  assign accept     = any_valid && can_accept && !rst;

  generate
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_ready
      assign req_ready[gi] = accept && (grant_idx == ID_W'(gi));
    end
  endgenerate

  // ---------------------------------------------------------------------
  // Shared ALU, fed by the winning requester's operands.
  // ---------------------------------------------------------------------
  assign alu_op   = req_op[grant_idx];
  assign alu_src1 = req_src1[grant_idx];
  assign alu_src2 = req_src2[grant_idx];
  assign shamt    = alu_src2[4:0];

  always_comb begin
    alu_result = '0;
    case (alu_op)
      ALU_ADD:  alu_result = alu_src1 + alu_src2;
      ALU_SUB:  alu_result = alu_src1 - alu_src2;
      ALU_SLL:  alu_result = alu_src1 << shamt;
      ALU_SLT:  alu_result = {31'd0, ($signed(alu_src1) < $signed(alu_src2))};
      ALU_SLTU: alu_result = {31'd0, (alu_src1 < alu_src2)};
      ALU_XOR:  alu_result = alu_src1 ^ alu_src2;
      ALU_SRL:  alu_result = alu_src1 >> shamt;
      ALU_SRA:  alu_result = $unsigned($signed(alu_src1) >>> shamt);
      ALU_OR:   alu_result = alu_src1 | alu_src2;
      ALU_AND:  alu_result = alu_src1 & alu_src2;
      default:  alu_result = '0;
    endcase
  end

  // ---------------------------------------------------------------------
  // Response slot FSM. An accept always loads the slot; this covers the
  // drain-and-refill case in FULL, giving one result per cycle.
  // ---------------------------------------------------------------------
  always_comb begin
    state_next    = state_reg;
    rsp_id_next   = rsp_id_reg;
    rsp_data_next = rsp_data_reg;
    rr_ptr_next   = rr_ptr_reg;
    case (state_reg)
      ST_EMPTY: begin
        if (accept) begin
          state_next = ST_FULL;
        end
      end
      ST_FULL: begin
        if (!accept && rsp_ready) begin
          state_next = ST_EMPTY;
        end
      end
      default: state_next = ST_EMPTY;
    endcase
    if (accept) begin
      rsp_id_next   = grant_idx;
      rsp_data_next = alu_result;
      rr_ptr_next   = (grant_idx == ID_W'(NUM_REQ - 1)) ? '0 : grant_idx + ID_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= ST_EMPTY;
      rsp_id_reg   <= '0;
      rsp_data_reg <= '0;
      rr_ptr_reg   <= '0;
    end else begin
      state_reg    <= state_next;
      rsp_id_reg   <= rsp_id_next;
      rsp_data_reg <= rsp_data_next;
      rr_ptr_reg   <= rr_ptr_next;
    end
  end

  assign rsp_valid = (state_reg == ST_FULL);
  assign rsp_id    = rsp_id_reg;
  assign rsp_data  = rsp_data_reg;

`ifdef SC_CORE_OZ_ALU_ARB_PERF_EN
  // Per-requester grant counters, saturating so a long run never wraps
  // back to a misleadingly small value.
  generate
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_perf
      logic [15:0] cnt_reg;
      always_ff @(posedge clk) begin
        if (rst) begin
          cnt_reg <= '0;
        end else if (req_ready[gi] && (cnt_reg != 16'hFFFF)) begin
          cnt_reg <= cnt_reg + 16'd1;
        end
      end
      assign perf_grant_cnt[gi] = cnt_reg;
    end
  endgenerate
`endif

endmodule

// File: tb/tb_sc_core_oz_alu_arb.sv
// ---------------------------------------------------------------------------
// tb_sc_core_oz_alu_arb
//
// Directed-stimulus bench for sc_core_oz_alu_arb (NUM_REQ = 2). A reference
// model of the arbiter and response slot is checked against the DUT on every
// falling clock edge, and the directed sequences also check hand-computed
// literal values.
// ---------------------------------------------------------------------------
module tb_sc_core_oz_alu_arb;
  import sc_core_oz_alu_arb_pkg::*;

  localparam int NUM_REQ = 2;
  localparam int ID_W    = 1;

  logic                     clk;
  logic                     rst;
  logic [NUM_REQ-1:0]       req_valid;
  alu_op_e [NUM_REQ-1:0]    req_op;
  logic [NUM_REQ-1:0][31:0] req_src1;
  logic [NUM_REQ-1:0][31:0] req_src2;
  logic [NUM_REQ-1:0]       req_ready;
  logic                     rsp_valid;
  logic [ID_W-1:0]          rsp_id;
  logic [31:0]              rsp_data;
  logic                     rsp_ready;
`ifdef SC_CORE_OZ_ALU_ARB_PERF_EN
  logic [NUM_REQ-1:0][15:0] perf_grant_cnt;
`endif

  int checks   = 0;
  int failures = 0;

  sc_core_oz_alu_arb #(.NUM_REQ(NUM_REQ)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_op    (req_op),
    .req_src1  (req_src1),
    .req_src2  (req_src2),
    .req_ready (req_ready),
    .rsp_valid (rsp_valid),
    .rsp_id    (rsp_id),
    .rsp_data  (rsp_data),
    .rsp_ready (rsp_ready)
`ifdef SC_CORE_OZ_ALU_ARB_PERF_EN
    ,
    .perf_grant_cnt (perf_grant_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference ALU written from the operation definitions.
  function automatic logic [31:0] alu_ref(input alu_op_e op, input logic [31:0] a,
                                          input logic [31:0] b);
    logic [4:0]  sh;
    logic [63:0] ext;
    sh  = b[4:0];
    ext = {{32{a[31]}}, a};
    case (op)
      ALU_ADD:  return a + b;
      ALU_SUB:  return a + ~b + 32'd1;
      ALU_SLL:  return a << sh;
      ALU_SLT:  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      ALU_SLTU: return (a < b) ? 32'd1 : 32'd0;
      ALU_XOR:  return a ^ b;
      ALU_SRL:  return a >> sh;
      ALU_SRA:  begin ext = ext >> sh; return ext[31:0]; end
      ALU_OR:   return a | b;
      ALU_AND:  return a & b;
      default:  return 32'd0;
    endcase
  endfunction

  // -------------------------------------------------------------------------
  // Reference model plus per-cycle comparison. Inputs change just after the
  // rising edge, so the values seen here on the falling edge are the ones the
  // DUT sees at the next rising edge.
  // -------------------------------------------------------------------------
  logic        m_full = 1'b0;
  int          m_id   = 0;
  logic [31:0] m_data = 32'd0;
  int          m_ptr  = 0;
  int          m_cnt [NUM_REQ];

  initial for (int i = 0; i < NUM_REQ; i++) m_cnt[i] = 0;

  always @(negedge clk) begin
    int                 g;
    int                 j;
    logic [NUM_REQ-1:0] exp_ready;
    g         = -1;
    exp_ready = '0;
    if (!rst && (!m_full || rsp_ready)) begin
      for (int k = 0; k < NUM_REQ; k++) begin
        j = (m_ptr + k) % NUM_REQ;
        if (g < 0 && req_valid[j]) g = j;
      end
      if (g >= 0) exp_ready[g] = 1'b1;
    end
    check("model.req_ready", 32'(req_ready), 32'(exp_ready));
    check("model.rsp_valid", 32'(rsp_valid), 32'(m_full));
    check("model.rsp_id",    32'(rsp_id),    32'(m_id));
    check("model.rsp_data",  rsp_data,       m_data);
`ifdef SC_CORE_OZ_ALU_ARB_PERF_EN
    for (int i = 0; i < NUM_REQ; i++)
      check("model.perf_cnt", 32'(perf_grant_cnt[i]), 32'(m_cnt[i]));
`endif
    if (rst) begin
      m_full = 1'b0;
      m_id   = 0;
      m_data = 32'd0;
      m_ptr  = 0;
      for (int i = 0; i < NUM_REQ; i++) m_cnt[i] = 0;
    end else if (g >= 0) begin
      m_full = 1'b1;
      m_id   = g;
      m_data = alu_ref(req_op[g], req_src1[g], req_src2[g]);
      m_ptr  = (g + 1) % NUM_REQ;
      if (m_cnt[g] < 65535) m_cnt[g]++;
    end else if (rsp_ready) begin
      m_full = 1'b0;
    end
  end

  // Watchdog so the run always ends.
  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic to_drive();
    @(posedge clk);
    #1;
  endtask

  task automatic to_neg();
    @(negedge clk);
  endtask

  task automatic set_req(input int i, input alu_op_e op, input logic [31:0] a,
                         input logic [31:0] b);
    req_op[i]   = op;
    req_src1[i] = a;
    req_src2[i] = b;
  endtask

  // Hand-computed ALU vectors for requester 0.
  alu_op_e     v_op  [10];
  logic [31:0] v_a   [10];
  logic [31:0] v_b   [10];
  logic [31:0] v_exp [10];

  int          alt_g [4];
  logic [31:0] alt_d [4];

  initial begin
    v_op[0] = ALU_SLT;         v_a[0] = 32'hFFFFFFFF; v_b[0] = 32'd1;        v_exp[0] = 32'd1;
    v_op[1] = ALU_SLTU;        v_a[1] = 32'hFFFFFFFF; v_b[1] = 32'd1;        v_exp[1] = 32'd0;
    v_op[2] = ALU_SLL;         v_a[2] = 32'd1;        v_b[2] = 32'h21;       v_exp[2] = 32'd2;
    v_op[3] = alu_op_e'(4'hF); v_a[3] = 32'h1234;     v_b[3] = 32'h5678;     v_exp[3] = 32'd0;
    v_op[4] = ALU_SRL;         v_a[4] = 32'h80000000; v_b[4] = 32'd4;        v_exp[4] = 32'h08000000;
    v_op[5] = ALU_SUB;         v_a[5] = 32'd0;        v_b[5] = 32'd1;        v_exp[5] = 32'hFFFFFFFF;
    v_op[6] = ALU_ADD;         v_a[6] = 32'hFFFFFFFF; v_b[6] = 32'd2;        v_exp[6] = 32'd1;
    v_op[7] = ALU_OR;          v_a[7] = 32'hF0000000; v_b[7] = 32'h0000000F; v_exp[7] = 32'hF000000F;
    v_op[8] = ALU_AND;         v_a[8] = 32'hFF00FF00; v_b[8] = 32'h0FF00FF0; v_exp[8] = 32'h0F000F00;
    v_op[9] = ALU_SRA;         v_a[9] = 32'h7FFFFFFF; v_b[9] = 32'd31;       v_exp[9] = 32'd0;

    // rr_ptr is 1 after the first ADD, so the pair alternates starting at 1.
    alt_g[0] = 1; alt_d[0] = 32'hF8000000;
    alt_g[1] = 0; alt_d[1] = 32'd7;
    alt_g[2] = 1; alt_d[2] = 32'hF8000000;
    alt_g[3] = 0; alt_d[3] = 32'd7;

    rst       = 1'b1;
    req_valid = '0;
    rsp_ready = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) set_req(i, ALU_ADD, 32'd0, 32'd0);

    // Reset state.
    repeat (2) to_drive();
    rst = 1'b0;
    to_neg();
    check("reset.rsp_valid", 32'(rsp_valid), 32'd0);
    check("reset.rsp_data",  rsp_data,       32'd0);
    check("reset.rsp_id",    32'(rsp_id),    32'd0);
    check("reset.req_ready", 32'(req_ready), 32'd0);
    $display("txn reset: rsp_valid=%0d rsp_data=%h", rsp_valid, rsp_data);

    // Single ADD from requester 0.
    to_drive();
    rsp_ready = 1'b1;
    req_valid = 2'b01;
    set_req(0, ALU_ADD, 32'd5, 32'd7);
    to_neg();
    check("add.req_ready", 32'(req_ready), 32'b01);
    to_drive();
    req_valid = 2'b00;
    to_neg();
    check("add.rsp_valid", 32'(rsp_valid), 32'd1);
    check("add.rsp_data",  rsp_data,       32'd12);
    check("add.rsp_id",    32'(rsp_id),    32'd0);
    $display("txn add: id=%0d data=%h", rsp_id, rsp_data);

    // Both requesters continuously valid: grants alternate.
    to_drive();
    req_valid = 2'b11;
    set_req(0, ALU_SUB, 32'd10, 32'd3);
    set_req(1, ALU_SRA, 32'h80000000, 32'd4);
    for (int i = 0; i < 4; i++) begin
      to_neg();
      check("alt.req_ready", 32'(req_ready), 32'(1) << alt_g[i]);
      if (i > 0) begin
        check("alt.rsp_data", rsp_data,    alt_d[i-1]);
        check("alt.rsp_id",   32'(rsp_id), 32'(alt_g[i-1]));
        $display("txn alt: id=%0d data=%h", rsp_id, rsp_data);
      end
      to_drive();
    end

    // Backpressure: slot FULL with the last SUB result, req1 waiting.
    rsp_ready = 1'b0;
    req_valid = 2'b10;
    set_req(1, ALU_XOR, 32'h0000F0F0, 32'h00000FF0);
    for (int i = 0; i < 3; i++) begin
      to_neg();
      check("hold.req_ready", 32'(req_ready), 32'd0);
      check("hold.rsp_valid", 32'(rsp_valid), 32'd1);
      check("hold.rsp_data",  rsp_data,       32'd7);
      check("hold.rsp_id",    32'(rsp_id),    32'd0);
      $display("txn hold: id=%0d data=%h ready=%b", rsp_id, rsp_data, req_ready);
      to_drive();
    end
    rsp_ready = 1'b1;
    to_neg();
    check("hold.release_ready", 32'(req_ready), 32'b10);
    to_drive();
    req_valid = 2'b00;
    to_neg();
    check("hold.new_data", rsp_data,    32'h0000FF00);
    check("hold.new_id",   32'(rsp_id), 32'd1);
    $display("txn hold-release: id=%0d data=%h", rsp_id, rsp_data);

    // ALU operation table, requester 0 alone, accepted every cycle.
    to_drive();
    req_valid = 2'b01;
    for (int i = 0; i < 10; i++) begin
      set_req(0, v_op[i], v_a[i], v_b[i]);
      to_neg();
      check("alu.req_ready", 32'(req_ready), 32'b01);
      if (i > 0) begin
        check("alu.rsp_data", rsp_data, v_exp[i-1]);
        $display("txn alu[%0d]: data=%h", i - 1, rsp_data);
      end
      to_drive();
    end
    req_valid = 2'b00;
    to_neg();
    check("alu.rsp_data", rsp_data, v_exp[9]);
    $display("txn alu[9]: data=%h", rsp_data);

    // Reset while FULL; rr_ptr is 1 beforehand.
    to_drive();
    rsp_ready = 1'b0;
    req_valid = 2'b01;
    set_req(0, ALU_ADD, 32'd1, 32'd1);
    to_neg();
    check("rst.pre_accept", 32'(req_ready), 32'b01);
    to_drive();
    rst       = 1'b1;
    req_valid = 2'b11;
    set_req(0, ALU_ADD, 32'd2, 32'd3);
    set_req(1, ALU_AND, 32'hFF, 32'h0F);
    to_neg();
    check("rst.full_before", 32'(rsp_valid), 32'd1);
    check("rst.ready_in_rst", 32'(req_ready), 32'd0);
    to_drive();
    to_neg();
    check("rst.rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst.rsp_data",  rsp_data,       32'd0);
    check("rst.ready_in_rst2", 32'(req_ready), 32'd0);
    to_drive();
    rst       = 1'b0;
    rsp_ready = 1'b1;
    to_neg();
    check("rst.first_grant", 32'(req_ready), 32'b01);
    to_drive();
    req_valid = 2'b10;
    to_neg();
    check("rst.rsp_data0", rsp_data,       32'd5);
    check("rst.rsp_id0",   32'(rsp_id),    32'd0);
    check("rst.next_grant", 32'(req_ready), 32'b10);
    $display("txn post-reset: id=%0d data=%h", rsp_id, rsp_data);
    to_drive();
    req_valid = 2'b00;
    to_neg();
    check("rst.rsp_data1", rsp_data,    32'h0F);
    check("rst.rsp_id1",   32'(rsp_id), 32'd1);
    $display("txn post-reset: id=%0d data=%h", rsp_id, rsp_data);

    // Drain with no requests.
    to_drive();
    to_neg();
    check("drain.rsp_valid", 32'(rsp_valid), 32'd0);
    check("drain.rsp_data",  rsp_data,       32'h0F);
    $display("txn drain: rsp_valid=%0d data=%h", rsp_valid, rsp_data);

`ifdef SC_CORE_OZ_ALU_ARB_PERF_EN
    // Saturation of the grant counter.
    to_drive();
    rst = 1'b1;
    to_drive();
    rst       = 1'b0;
    rsp_ready = 1'b1;
    req_valid = 2'b01;
    set_req(0, ALU_ADD, 32'd0, 32'd0);
    repeat (70000) to_drive();
    req_valid = 2'b00;
    to_neg();
    check("perf.cnt0", 32'(perf_grant_cnt[0]), 32'h0000FFFF);
    check("perf.cnt1", 32'(perf_grant_cnt[1]), 32'd0);
    $display("txn perf: cnt0=%h cnt1=%h", perf_grant_cnt[0], perf_grant_cnt[1]);
`endif

    to_drive();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
